// File: rtl/vc_flit_queue_pkg.sv
// vc_flit_queue_pkg
//   Shared types for the multi-virtual-channel flit queue.
//   flit_t      : one flit as carried through the router input port
//   arbState_e  : pop-side grant state (free-running round robin, or frozen
//                 on a stalled consumer)
// No ports (package).

package vc_flit_queue_pkg;

   localparam int FLIT_W = 16;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic {
      ARB_FREE = 1'b0,
      ARB_HOLD = 1'b1
   } arbState_e;

endpackage

// File: rtl/vc_flit_queue_if.sv
// vc_flit_queue_if
//   Bundles the push and pop handshakes of vc_flit_queue plus the per-VC
//   occupancy/ready exports used for credit return.
//   Push side : pushed_flit, pushed_vc, pushed_flit_valid -> pushed_flit_ready
//   Pop side  : poped_flit_ready -> poped_flit_valid, poped_flit, poped_vc
//   Status    : vc_ready (per-VC not-full), vc_count (per-VC occupancy)
//   master = the router logic around the queue, slave = the queue itself.

interface vc_flit_queue_if #(
   parameter int NUM_VC = 4,
   parameter int DEPTH  = 8
);
   import vc_flit_queue_pkg::*;

   localparam int VC_W  = $clog2(NUM_VC);
   localparam int CNT_W = $clog2(DEPTH + 1);

   flit_t                              pushed_flit;
   logic [VC_W-1:0]                    pushed_vc;
   logic                               pushed_flit_valid;
   logic                               pushed_flit_ready;
   logic [NUM_VC-1:0]                  vc_ready;
   logic                               poped_flit_ready;
   logic                               poped_flit_valid;
   flit_t                              poped_flit;
   logic [VC_W-1:0]                    poped_vc;
   logic [NUM_VC-1:0][CNT_W-1:0]       vc_count;

   modport master (
      output pushed_flit,
      output pushed_vc,
      output pushed_flit_valid,
      input  pushed_flit_ready,
      input  vc_ready,
      output poped_flit_ready,
      input  poped_flit_valid,
      input  poped_flit,
      input  poped_vc,
      input  vc_count
   );

   modport slave (
      input  pushed_flit,
      input  pushed_vc,
      input  pushed_flit_valid,
      output pushed_flit_ready,
      output vc_ready,
      input  poped_flit_ready,
      output poped_flit_valid,
      output poped_flit,
      output poped_vc,
      output vc_count
   );

endinterface

// File: rtl/vc_flit_queue_rr_arbiter.sv
// rr_arbiter
//   Purely combinational rotate-priority arbiter. The requester searched
//   first is the one just after 'last_i', wrapping modulo N, so the most
//   recently served requester has the lowest priority.
//   req_i   : request vector
//   last_i  : index of the previously granted requester
//   grant_o : index of the winning requester (0 when none requests)
//   any_o   : at least one request is present

module rr_arbiter #(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] grant_o,
   output logic         any_o
);

   logic [W-1:0] idx;

   // Walk the candidates from farthest to nearest offset so the nearest
   // requesting candidate is the last one written and therefore wins.
   always_comb begin
      grant_o = '0;
      any_o   = 1'b0;
      idx     = '0;
      for (int i = N; i >= 1; i--) begin
         idx = W'((int'(last_i) + i) % N);
         if (req_i[idx]) begin
            grant_o = idx;
            any_o   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vc_flit_queue.sv
// vc_flit_queue
//   NUM_VC independent circular flit queues of DEPTH entries sharing one
//   push port (flit tagged with its VC) and one first-word-fall-through pop
//   port served round-robin across non-empty VCs. Sits ahead of route
//   compute / switch allocation at a router input port.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset (queued flits are discarded)
//   bus : vc_flit_queue_if slave modport carrying push/pop handshakes,
//         per-VC ready and per-VC occupancy

module vc_flit_queue #(
   parameter int NUM_VC = 4,
   parameter int DEPTH  = 8
) (
   input  logic            clk,
   input  logic            rst,
   vc_flit_queue_if.slave  bus
);
   import vc_flit_queue_pkg::*;

   localparam int VC_W  = $clog2(NUM_VC);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [VC_W-1:0]  LAST_VC  = VC_W'(NUM_VC - 1);

   flit_t              storage_q [NUM_VC][DEPTH];
   logic [PTR_W-1:0]   rdPtr_q   [NUM_VC];
   logic [PTR_W-1:0]   rdPtr_d   [NUM_VC];
   logic [PTR_W-1:0]   wrPtr_q   [NUM_VC];
   logic [PTR_W-1:0]   wrPtr_d   [NUM_VC];
   logic [CNT_W-1:0]   count_q   [NUM_VC];
   logic [CNT_W-1:0]   count_d   [NUM_VC];

   arbState_e          arbState_q;
   logic [VC_W-1:0]    heldVc_q;
   logic [VC_W-1:0]    lastGrant_q;

   logic [NUM_VC-1:0]  nonEmpty;
   logic [NUM_VC-1:0]  vcReady;
   logic [NUM_VC-1:0]  pushHit;
   logic [NUM_VC-1:0]  popHit;
   logic [VC_W-1:0]    arbGrant;
   logic [VC_W-1:0]    grant;
   logic               arbAny;
   logic               popValid;
   logic               pushFire;
   logic               popFire;
   flit_t              headFlit;

   // Status flags come only from registered counts, so a full VC stays
   // closed to pushes even when it is being popped in the same cycle.
   always_comb begin
      nonEmpty = '0;
      vcReady  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         nonEmpty[v] = (count_q[v] != '0);
         vcReady[v]  = (count_q[v] != FULL_CNT);
      end
   end

   rr_arbiter #(
      .N (NUM_VC)
   ) uArb (
      .req_i   (nonEmpty),
      .last_i  (lastGrant_q),
      .grant_o (arbGrant),
      .any_o   (arbAny)
   );

   // A stalled consumer freezes the grant so the presented flit cannot
   // change under it, even if a higher-priority VC fills up meanwhile.
   always_comb begin
      grant    = (arbState_q == ARB_HOLD) ? heldVc_q : arbGrant;
      popValid = arbAny;
      pushFire = bus.pushed_flit_valid && vcReady[bus.pushed_vc];
      popFire  = popValid && bus.poped_flit_ready;
      headFlit = storage_q[grant][rdPtr_q[grant]];
   end

   // Drive the slave side of the interface.
   always_comb begin
      bus.pushed_flit_ready = vcReady[bus.pushed_vc];
      bus.vc_ready          = vcReady;
      bus.poped_flit_valid  = popValid;
      bus.poped_vc          = grant;
      bus.poped_flit        = headFlit;
      bus.vc_count          = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         bus.vc_count[v] = count_q[v];
      end
   end

   // Per-VC next state. Push and pop on the same VC leave the count alone
   // while both pointers move; pointers wrap naturally at DEPTH.
   always_comb begin
      pushHit = '0;
      popHit  = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         pushHit[v] = pushFire && (bus.pushed_vc == VC_W'(v));
         popHit[v]  = popFire && (grant == VC_W'(v));
         wrPtr_d[v] = wrPtr_q[v] + PTR_W'(pushHit[v]);
         rdPtr_d[v] = rdPtr_q[v] + PTR_W'(popHit[v]);
         count_d[v] = count_q[v] + CNT_W'(pushHit[v]) - CNT_W'(popHit[v]);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wrPtr_q[v] <= '0;
            rdPtr_q[v] <= '0;
            count_q[v] <= '0;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            wrPtr_q[v] <= wrPtr_d[v];
            rdPtr_q[v] <= rdPtr_d[v];
            count_q[v] <= count_d[v];
         end
      end
   end

   // Flit storage is deliberately left uncleared on reset; the counts alone
   // decide what is valid.
   always_ff @(posedge clk) begin
      if (!rst && pushFire) begin
         storage_q[bus.pushed_vc][wrPtr_q[bus.pushed_vc]] <= bus.pushed_flit;
      end
   end

   // Grant-hold FSM and round-robin history. The last grant only moves on
   // a completed pop so a stall does not rotate priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         arbState_q  <= ARB_FREE;
         heldVc_q    <= '0;
         lastGrant_q <= LAST_VC;
      end else begin
         if (popFire) begin
            lastGrant_q <= grant;
         end
         case (arbState_q)
            ARB_FREE: begin
               if (popValid && !bus.poped_flit_ready) begin
                  arbState_q <= ARB_HOLD;
                  heldVc_q   <= grant;
               end
            end
            ARB_HOLD: begin
               if (popFire) begin
                  arbState_q <= ARB_FREE;
               end
            end
            default: arbState_q <= ARB_FREE;
         endcase
      end
   end

   // Occupancy bounds and no write into a full VC.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int v = 0; v < NUM_VC; v++) begin
            assert (count_q[v] <= FULL_CNT);
         end
         assert (!(pushFire && (count_q[bus.pushed_vc] == FULL_CNT)));
      end
   end

   // The presented flit and VC must not move while the consumer stalls.
   assert property (@(posedge clk) disable iff (rst)
      (popValid && !bus.poped_flit_ready) |=> ($stable(grant) && $stable(headFlit)));

endmodule

// File: tb/tb_vc_flit_queue.sv
// tb_vc_flit_queue
//   Directed self-checking bench for vc_flit_queue (NUM_VC=4, DEPTH=8).
//   Walks through reset, fill/drain of one VC, round-robin order, grant
//   stalls, full-VC push/pop interaction, push-to-pop latency and a reset
//   in the middle of traffic. Expected values are written out by hand.

module tb_vc_flit_queue;
   import vc_flit_queue_pkg::*;

   localparam int NUM_VC = 4;
   localparam int DEPTH  = 8;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   int   ord1 [4] = '{0, 3, 1, 2};
   int   ord2 [4] = '{2, 0, 1, 3};
   int   exp2 [4] = '{2, 3, 0, 1};

   vc_flit_queue_if #(.NUM_VC(NUM_VC), .DEPTH(DEPTH)) bus ();

   vc_flit_queue #(
      .NUM_VC (NUM_VC),
      .DEPTH  (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack four per-VC counts the way vc_count is laid out (VC0 in the LSBs).
   function automatic logic [15:0] cnts(input int c0, input int c1, input int c2, input int c3);
      return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
   endfunction

   // Move to 1 time unit after the next rising edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive all producer/consumer inputs, then let combinational outputs settle.
   task automatic applyStimulus(input logic pushValid, input int pushVc,
                                input flit_t flit, input logic popReady);
      bus.pushed_flit_valid = pushValid;
      bus.pushed_vc         = 2'(pushVc);
      bus.pushed_flit       = flit;
      bus.poped_flit_ready  = popReady;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(1'b0, 0, '0, 1'b0);

      // Reset held for two edges.
      tick;
      tick;
      rst = 1'b0;
      #1;
      $display("[TB] reset state");
      checkOutput("rst_count",      32'(bus.vc_count),          32'(cnts(0, 0, 0, 0)));
      checkOutput("rst_valid",      32'(bus.poped_flit_valid),  32'd0);
      checkOutput("rst_vc_ready",   32'(bus.vc_ready),          32'hF);
      checkOutput("rst_push_ready", 32'(bus.pushed_flit_ready), 32'd1);
      checkOutput("rst_poped_vc",   32'(bus.poped_vc),          32'd0);

      // Fill VC2 with payloads 0..7 while the consumer stalls.
      $display("[TB] fill and drain VC2");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2, flit_t'(i), 1'b0);
         tick;
      end
      applyStimulus(1'b1, 2, 16'h0008, 1'b0);
      checkOutput("full_count",      32'(bus.vc_count),          32'(cnts(0, 0, 8, 0)));
      checkOutput("full_vc_ready",   32'(bus.vc_ready),          32'b1011);
      checkOutput("full_push_ready", 32'(bus.pushed_flit_ready), 32'd0);
      checkOutput("full_valid",      32'(bus.poped_flit_valid),  32'd1);
      checkOutput("full_head",       32'(bus.poped_flit),        32'h0);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("ninth_refused", 32'(bus.vc_count), 32'(cnts(0, 0, 8, 0)));
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("drain%0d_vc", i),   32'(bus.poped_vc),   32'd2);
         checkOutput($sformatf("drain%0d_flit", i), 32'(bus.poped_flit), 32'(i));
         tick;
      end
      checkOutput("drained_count",    32'(bus.vc_count),         32'(cnts(0, 0, 0, 0)));
      checkOutput("drained_valid",    32'(bus.poped_flit_valid), 32'd0);
      checkOutput("drained_vc_ready", 32'(bus.vc_ready),         32'hF);

      // Refill after both pointers have wrapped.
      applyStimulus(1'b1, 2, 16'h0020, 1'b0);
      tick;
      applyStimulus(1'b1, 2, 16'h0021, 1'b0);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("wrap0_flit", 32'(bus.poped_flit), 32'h20);
      tick;
      checkOutput("wrap1_flit", 32'(bus.poped_flit), 32'h21);
      tick;
      checkOutput("wrap_empty", 32'(bus.poped_flit_valid), 32'd0);

      // Round robin from last_grant=2: expect 0,1,2,3.
      $display("[TB] round robin");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, ord1[k], flit_t'(16'h30 + ord1[k]), 1'b0);
         tick;
      end
      applyStimulus(1'b0, 0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("rr1_%0d_vc", k),   32'(bus.poped_vc),   32'(k));
         checkOutput($sformatf("rr1_%0d_flit", k), 32'(bus.poped_flit), 32'(16'h30 + k));
         tick;
      end
      checkOutput("rr1_empty", 32'(bus.poped_flit_valid), 32'd0);

      // Serve VC1 alone to move last_grant to 1, then expect 2,3,0,1.
      applyStimulus(1'b1, 1, 16'h0041, 1'b0);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("rr_setup_vc", 32'(bus.poped_vc), 32'd1);
      tick;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, ord2[k], flit_t'(16'h50 + ord2[k]), 1'b0);
         tick;
      end
      applyStimulus(1'b0, 0, '0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("rr2_%0d_vc", k),   32'(bus.poped_vc),   32'(exp2[k]));
         checkOutput($sformatf("rr2_%0d_flit", k), 32'(bus.poped_flit), 32'(16'h50 + exp2[k]));
         tick;
      end

      // Stall on VC1 while VC0 (next in line) fills up.
      $display("[TB] stall");
      applyStimulus(1'b1, 1, 16'h0061, 1'b0);
      tick;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 0, flit_t'(16'h70 + i), 1'b0);
         checkOutput($sformatf("stall%0d_vc", i),   32'(bus.poped_vc),   32'd1);
         checkOutput($sformatf("stall%0d_flit", i), 32'(bus.poped_flit), 32'h61);
         tick;
      end
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("stall_release_vc",    32'(bus.poped_vc),   32'd1);
      checkOutput("stall_release_flit",  32'(bus.poped_flit), 32'h61);
      checkOutput("stall_release_count", 32'(bus.vc_count),   32'(cnts(5, 1, 0, 0)));
      tick;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("after_stall%0d_vc", i),   32'(bus.poped_vc),   32'd0);
         checkOutput($sformatf("after_stall%0d_flit", i), 32'(bus.poped_flit), 32'(16'h70 + i));
         tick;
      end
      checkOutput("after_stall_empty", 32'(bus.poped_flit_valid), 32'd0);

      // Full VC3: same-cycle pop does not open it for the push.
      $display("[TB] full VC push/pop");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 3, flit_t'(16'h80 + i), 1'b0);
         tick;
      end
      applyStimulus(1'b1, 3, 16'h0088, 1'b1);
      checkOutput("vc3_full_ready", 32'(bus.pushed_flit_ready), 32'd0);
      checkOutput("vc3_full_count", 32'(bus.vc_count),          32'(cnts(0, 0, 0, 8)));
      checkOutput("vc3_full_vc",    32'(bus.poped_vc),          32'd3);
      checkOutput("vc3_full_head",  32'(bus.poped_flit),        32'h80);
      tick;
      checkOutput("vc3_refused_count", 32'(bus.vc_count),          32'(cnts(0, 0, 0, 7)));
      checkOutput("vc3_reopen_ready",  32'(bus.pushed_flit_ready), 32'd1);
      checkOutput("vc3_head_81",       32'(bus.poped_flit),        32'h81);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("vc3_both_count", 32'(bus.vc_count), 32'(cnts(0, 0, 0, 7)));
      for (int i = 0; i < 7; i++) begin
         checkOutput($sformatf("vc3_drain%0d", i), 32'(bus.poped_flit), 32'(16'h82 + i));
         tick;
      end
      checkOutput("vc3_empty", 32'(bus.poped_flit_valid), 32'd0);

      // Push-to-pop latency: no same-cycle bypass.
      $display("[TB] latency and mid-traffic reset");
      applyStimulus(1'b1, 0, 16'h0090, 1'b1);
      checkOutput("lat_before_edge", 32'(bus.poped_flit_valid), 32'd0);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("lat_after_valid", 32'(bus.poped_flit_valid), 32'd1);
      checkOutput("lat_after_flit",  32'(bus.poped_flit),       32'h90);
      checkOutput("lat_after_vc",    32'(bus.poped_vc),         32'd0);
      tick;
      checkOutput("lat_empty", 32'(bus.poped_flit_valid), 32'd0);

      // Reset with three flits queued and a push/pop handshake in flight.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1, flit_t'(16'hA0 + i), 1'b0);
         tick;
      end
      checkOutput("pre_rst_count", 32'(bus.vc_count), 32'(cnts(0, 3, 0, 0)));
      rst = 1'b1;
      applyStimulus(1'b1, 1, 16'h00A3, 1'b1);
      tick;
      rst = 1'b0;
      applyStimulus(1'b0, 0, '0, 1'b0);
      checkOutput("mid_rst_count",    32'(bus.vc_count),         32'(cnts(0, 0, 0, 0)));
      checkOutput("mid_rst_valid",    32'(bus.poped_flit_valid), 32'd0);
      checkOutput("mid_rst_vc_ready", 32'(bus.vc_ready),         32'hF);
      checkOutput("mid_rst_poped_vc", 32'(bus.poped_vc),         32'd0);

      // Queue still works after the mid-traffic reset.
      applyStimulus(1'b1, 2, 16'h00B0, 1'b0);
      tick;
      applyStimulus(1'b0, 0, '0, 1'b1);
      checkOutput("post_rst_vc",   32'(bus.poped_vc),   32'd2);
      checkOutput("post_rst_flit", 32'(bus.poped_flit), 32'hB0);
      tick;
      checkOutput("post_rst_empty", 32'(bus.poped_flit_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
